// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register for the five-stage MIPS core.
// One instance sits at each of the F/D, D/E, E/M and M/W boundaries and
// carries one instruction slot from the upstream stage to the downstream one.
//
// Per-edge action, highest priority first:
//   reset  -> PC = RESET_PC, everything else cleared
//   req    -> PC = HANDLER_PC, everything else cleared (handler bubble)
//   flush  -> bubble: instr/data/valid/exccode cleared, PC and BD captured
//   stall  -> hold all contents
//   load   -> capture all fields, merging the exception code
//
// Parameters:
//   DATA_W     width of one data lane
//   LANES      number of data lanes (>= 1)
//   EXC_W      exception-code width; code 0 means "no exception"
//   RESET_PC   PC loaded on reset and at power-up
//   HANDLER_PC PC loaded on an exception request
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   req          exception/interrupt request
//   flush        insert a bubble on this edge
//   stall        hold current contents
//   in_pc        upstream PC
//   in_instr     upstream instruction word
//   in_data      upstream data lanes, lane k at [k*DATA_W +: DATA_W]
//   in_valid     upstream slot holds a real instruction
//   in_exccode   exception code already attached upstream
//   in_exc_new   exception detected in the upstream stage this cycle
//   in_bd        upstream instruction is in a branch-delay slot
//   out_*        registered copies of the matching inputs
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANES      = 3,
  parameter int unsigned EXC_W      = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      flush,
  input  logic                      stall,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_instr,
  input  logic [DATA_W*LANES-1:0]   in_data,
  input  logic                      in_valid,
  input  logic [EXC_W-1:0]          in_exccode,
  input  logic [EXC_W-1:0]          in_exc_new,
  input  logic                      in_bd,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_instr,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic                      out_valid,
  output logic [EXC_W-1:0]          out_exccode,
  output logic                      out_bd
);

  localparam int unsigned DW = DATA_W * LANES;

  // Action chosen for the coming edge, in priority order.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_REQ,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_LOAD
  } action_e;

  // Everything the stage carries, kept together so each action is one
  // assignment of the whole slot.
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [DW-1:0]    data;
    logic             valid;
    logic [EXC_W-1:0] exccode;
    logic             bd;
  } stage_t;

  action_e          action;
  logic [EXC_W-1:0] merged_exc;
  stage_t           stage_d;

  // NOTE: the register gets its reset value as a declaration initialiser so
  // power-up contents match the reset state without waiting for a reset edge.
  stage_t stage_q = '{pc: RESET_PC, instr: '0, data: '0, valid: 1'b0,
                      exccode: '0, bd: 1'b0};

  // Priority decode of the control inputs.
  always_comb begin
    if (reset)      action = ACT_RESET;
    else if (req)   action = ACT_REQ;
    else if (flush) action = ACT_FLUSH;   // flush beats stall: bubble goes in
    else if (stall) action = ACT_HOLD;
    else            action = ACT_LOAD;
  end

  // An exception attached further upstream is older and always wins; a
  // newly detected one only applies to a real instruction.
  always_comb begin
    merged_exc = '0;
    if (in_valid) begin
      merged_exc = (in_exccode != '0) ? in_exccode : in_exc_new;
    end
  end

  // Next-state selection for the whole slot.
  always_comb begin
    // NOTE: defaulting to the held value first means every path assigns
    // stage_d, so no latch is inferred and "hold" needs no explicit branch.
    stage_d = stage_q;
    unique case (action)
      ACT_RESET: begin
        stage_d    = '0;
        stage_d.pc = RESET_PC;
      end
      ACT_REQ: begin
        stage_d    = '0;
        stage_d.pc = HANDLER_PC;
      end
      ACT_FLUSH: begin
        // Bubble keeps the held instruction's PC and BD so an interrupt
        // taken on the bubble still reports the right EPC.
        stage_d    = '0;
        stage_d.pc = in_pc;
        stage_d.bd = in_bd;
      end
      ACT_HOLD: begin
        stage_d = stage_q;
      end
      ACT_LOAD: begin
        stage_d.pc      = in_pc;
        stage_d.instr   = in_instr;
        stage_d.data    = in_data;
        stage_d.valid   = in_valid;
        stage_d.exccode = merged_exc;
        stage_d.bd      = in_bd;
      end
      default: stage_d = stage_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign out_pc      = stage_q.pc;
  assign out_instr   = stage_q.instr;
  assign out_data    = stage_q.data;
  assign out_valid   = stage_q.valid;
  assign out_exccode = stage_q.exccode;
  assign out_bd      = stage_q.bd;

endmodule
